// File: rtl/ika9958_cen_gen_if.sv
// Signal bundle between the clock-enable generator and its consumer:
// master enable, per-channel ratio/pause, sync strobe, and generated enables.
interface ika9958_cen_gen_if #(
    parameter int NCH  = 3,
    parameter int DIVW = 4
);
    logic                  i_MCEN;
    logic [NCH*DIVW-1:0]   i_DIV;
    logic [NCH-1:0]        i_PAUSE;
    logic                  i_SYNC_n;
    logic                  i_SYNC_EN;
    logic [NCH-1:0]        o_PCEN;
    logic [NCH-1:0]        o_NCEN;
    logic [NCH-1:0]        o_CLK;
    logic                  o_RST_sync_n;

    modport master (
        output i_MCEN, i_DIV, i_PAUSE, i_SYNC_n, i_SYNC_EN,
        input  o_PCEN, o_NCEN, o_CLK, o_RST_sync_n
    );

    modport slave (
        input  i_MCEN, i_DIV, i_PAUSE, i_SYNC_n, i_SYNC_EN,
        output o_PCEN, o_NCEN, o_CLK, o_RST_sync_n
    );
endinterface

// File: rtl/ika9958_cen_gen.sv
// Multi-channel clock-enable divider: derives per-channel rising/falling enables
// and a reference clock level from a master clock enable, with pause and resync.
module ika9958_cen_gen #(
    parameter int NCH     = 3,
    parameter int DIVW    = 4,
    parameter int RSTSYNC = 2
) (
    input  logic              i_CLK,
    input  logic              i_RST_n,
    ika9958_cen_gen_if.slave  bus
);

    logic [RSTSYNC-1:0] rst_sr_q;
    logic [RSTSYNC-1:0] rst_sr_d;
    logic               rst_ok;
    logic [2:0]         sync_sr_q;
    logic [2:0]         sync_sr_d;
    logic               sync_ev;
    logic [NCH-1:0]     pcen_vec;
    logic [NCH-1:0]     ncen_vec;
    logic [NCH-1:0]     clk_vec;

    always_comb begin
        rst_sr_d  = {rst_sr_q[RSTSYNC-2:0], 1'b1};
        sync_sr_d = {sync_sr_q[1:0], bus.i_SYNC_n};
    end

    // Reset release advances only with the master enable so all channels start together.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            rst_sr_q  <= '0;
            sync_sr_q <= 3'b111;
        end else if (bus.i_MCEN) begin
            rst_sr_q  <= rst_sr_d;
            sync_sr_q <= sync_sr_d;
        end
    end

    assign rst_ok  = rst_sr_q[RSTSYNC-1];
    // Falling edge of the strobe, seen after the first sampling stage settles.
    assign sync_ev = bus.i_SYNC_EN & ~sync_sr_q[1] & sync_sr_q[2];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIVW-1:0] cnt_q;
            logic [DIVW-1:0] cnt_d;
            logic [DIVW-1:0] divl_q;
            logic [DIVW-1:0] divl_d;
            logic [DIVW-1:0] d_eff;
            logic [DIVW-1:0] h_len;
            logic [DIVW-1:0] div_in;
            logic            clk_q;
            logic            clk_d;
            logic            wrap;
            logic            pause;
            logic            pcen;
            logic            ncen;

            assign div_in = bus.i_DIV[gi*DIVW +: DIVW];
            assign pause  = bus.i_PAUSE[gi];
            assign d_eff  = (divl_q < DIVW'(2)) ? DIVW'(2) : divl_q;
            assign h_len  = d_eff >> 1;
            // cnt can sit above D-1 after reset or a ratio change; treat that as wrap too.
            assign wrap   = (cnt_q >= (d_eff - DIVW'(1)));
            assign pcen   = bus.i_MCEN & rst_ok & ~pause & (wrap | sync_ev);
            assign ncen   = bus.i_MCEN & rst_ok & ~sync_ev & (cnt_q == (h_len - DIVW'(1)));

            always_comb begin
                cnt_d  = cnt_q;
                divl_d = divl_q;
                clk_d  = clk_q;
                if (!rst_ok) begin
                    divl_d = div_in;
                end else if (pause) begin
                    if (wrap) divl_d = div_in;
                    else      cnt_d  = cnt_q + DIVW'(1);
                end else if (sync_ev) begin
                    cnt_d = '0;
                    if (wrap) divl_d = div_in;
                end else if (wrap) begin
                    cnt_d  = '0;
                    divl_d = div_in;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
                if (pcen)      clk_d = 1'b1;
                else if (ncen) clk_d = 1'b0;
            end

            always_ff @(posedge i_CLK or negedge i_RST_n) begin
                if (!i_RST_n) begin
                    cnt_q  <= '1;
                    divl_q <= '1;
                    clk_q  <= 1'b0;
                end else if (bus.i_MCEN) begin
                    cnt_q  <= cnt_d;
                    divl_q <= divl_d;
                    clk_q  <= clk_d;
                end
            end

            assign pcen_vec[gi] = pcen;
            assign ncen_vec[gi] = ncen;
            assign clk_vec[gi]  = clk_q;
        end
    endgenerate

    assign bus.o_PCEN       = pcen_vec;
    assign bus.o_NCEN       = ncen_vec;
    assign bus.o_CLK        = clk_vec;
    assign bus.o_RST_sync_n = rst_ok;

endmodule
